// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: pointer-addressed register bank behind the I2C slave.
// Received bytes are staged in a shadow bank and copied to the active bank
// in one cycle on STOP, so downstream logic never sees a half-written set.
module i2c_reg_ctrl #(
  parameter int          NUM_REGS    = 8,
  parameter int          PTR_W       = 3,
  parameter logic [7:0]  RESET_VALUE = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            data_i,
  input  logic                  data_valid_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic [7:0]            rd_data_o,
  output logic [PTR_W-1:0]      ptr_o,
  output logic                  wr_pulse_o,
  output logic                  commit_o,
  output logic                  err_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_DATA, S_IGNORE} state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic             r_dirty;
  logic             r_err;
  logic             r_wr_pulse;
  logic             r_commit;
  logic [7:0]       r_shadow [NUM_REGS];
  logic [7:0]       r_active [NUM_REGS];

  logic [7:0]       w_shadow_nxt [NUM_REGS];
  logic [7:0]       w_rd_data;
  logic [PTR_W-1:0] w_ptr_inc;
  logic             w_byte, w_ptr_in_range, w_ptr_ok, w_ptr_bad, w_wr;
  logic             w_dirty_nxt, w_err_nxt, w_do_commit, w_do_discard;

  // A START in the same cycle swallows the byte.
  assign w_byte         = data_valid_i & ~start_i;
  assign w_ptr_in_range = ({1'b0, data_i} < 9'(NUM_REGS));
  assign w_ptr_ok       = w_byte && (r_state == S_PTR) && w_ptr_in_range;
  assign w_ptr_bad      = w_byte && (r_state == S_PTR) && !w_ptr_in_range;
  assign w_wr           = w_byte && (r_state == S_DATA);
  assign w_ptr_inc      = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;

  // STOP sees the effect of a byte arriving in the same cycle.
  assign w_dirty_nxt  = r_dirty | w_wr;
  assign w_err_nxt    = r_err | w_ptr_bad;
  assign w_do_commit  = stop_i && w_dirty_nxt && !w_err_nxt;
  assign w_do_discard = stop_i && w_err_nxt;

  // Shadow bank including this cycle's write, used for both update and commit.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++)
      w_shadow_nxt[k] = (w_wr && r_ptr == PTR_W'(k)) ? data_i : r_shadow[k];
  end

  // Read mux over the active bank at the current pointer.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (r_ptr == PTR_W'(k)) w_rd_data = r_active[k];
  end

  // Control FSM, banks and strobes; START is applied after STOP handling.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_dirty    <= 1'b0;
      r_err      <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_commit   <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_shadow[k] <= RESET_VALUE;
        r_active[k] <= RESET_VALUE;
      end
    end else begin
      r_wr_pulse <= w_wr;
      r_commit   <= w_do_commit;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_shadow[k] <= w_do_discard ? r_active[k] : w_shadow_nxt[k];
        if (w_do_commit) r_active[k] <= w_shadow_nxt[k];
      end
      if (w_ptr_ok)  r_ptr <= data_i[PTR_W-1:0];
      else if (w_wr) r_ptr <= w_ptr_inc;
      r_dirty <= stop_i ? 1'b0 : w_dirty_nxt;
      r_err   <= start_i ? 1'b0 : w_err_nxt;
      if (start_i)        r_state <= S_PTR;
      else if (stop_i)    r_state <= S_IDLE;
      else if (w_ptr_ok)  r_state <= S_DATA;
      else if (w_ptr_bad) r_state <= S_IGNORE;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_o[8*k +: 8] = r_active[k];
  end

  assign rd_data_o  = w_rd_data;
  assign ptr_o      = r_ptr;
  assign wr_pulse_o = r_wr_pulse;
  assign commit_o   = r_commit;
  assign err_o      = r_err;
  assign busy_o     = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: directed scenarios plus random event streams,
// a transaction-level model, and a monitor draining expected strobes.
module tb_i2c_reg_ctrl;
  localparam int N  = 8;
  localparam int PW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     data_i;
  logic           data_valid_i, start_i, stop_i;
  logic [N*8-1:0] regs_o;
  logic [7:0]     rd_data_o;
  logic [PW-1:0]  ptr_o;
  logic           wr_pulse_o, commit_o, err_o, busy_o;

  i2c_reg_ctrl #(.NUM_REGS(N), .PTR_W(PW), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .reset(reset), .data_i(data_i), .data_valid_i(data_valid_i),
    .start_i(start_i), .stop_i(stop_i), .regs_o(regs_o), .rd_data_o(rd_data_o),
    .ptr_o(ptr_o), .wr_pulse_o(wr_pulse_o), .commit_o(commit_o), .err_o(err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 expecting pointer, 2 data, 3 discarding
  int         m_st, m_ptr;
  bit         m_dirty, m_err;
  logic [7:0] m_sh [N];
  logic [7:0] m_act[N];

  int             wr_q[$];
  logic [N*8-1:0] commit_q[$];
  logic [N*8-1:0] mon_regs;
  logic           rst_q;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*8-1:0] pack_act();
    logic [N*8-1:0] p;
    for (int k = 0; k < N; k++) p[8*k +: 8] = m_act[k];
    return p;
  endfunction

  task automatic model_reset();
    m_st = 0; m_ptr = 0; m_dirty = 0; m_err = 0;
    for (int k = 0; k < N; k++) begin m_sh[k] = 8'h00; m_act[k] = 8'h00; end
  endtask

  // Effect of one cycle of events, in the order the protocol defines.
  task automatic model_step(input bit s, input bit p, input bit v, input logic [7:0] d);
    if (v && !s) begin
      if (m_st == 1) begin
        if (int'(d) < N) begin m_ptr = int'(d); m_st = 2; end
        else begin m_err = 1; m_st = 3; end
      end else if (m_st == 2) begin
        m_sh[m_ptr] = d;
        m_dirty = 1;
        m_ptr = (m_ptr + 1) % N;
        wr_q.push_back(m_ptr);
      end
    end
    if (p) begin
      if (m_dirty && !m_err) begin
        for (int k = 0; k < N; k++) m_act[k] = m_sh[k];
        commit_q.push_back(pack_act());
      end
      if (m_err) for (int k = 0; k < N; k++) m_sh[k] = m_act[k];
      m_dirty = 0;
      m_st = 0;
    end
    if (s) begin m_st = 1; m_err = 0; end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ptr"},  64'(ptr_o),     64'(m_ptr));
    chk({tag, ".err"},  64'(err_o),     64'(m_err));
    chk({tag, ".busy"}, 64'(busy_o),    64'(m_st != 0));
    chk({tag, ".rd"},   64'(rd_data_o), 64'(m_act[m_ptr]));
  endtask

  // One clock of stimulus; called just after a rising edge.
  task automatic cyc(input bit s, input bit p, input bit v, input logic [7:0] d);
    start_i = s; stop_i = p; data_valid_i = v; data_i = d;
    model_step(s, p, v, d);
    @(posedge clk); #1;
    start_i = 0; stop_i = 0; data_valid_i = 0; data_i = 8'h00;
    check_state("cyc");
  endtask

  task automatic st();                   cyc(1, 0, 0, 8'h00); endtask
  task automatic sp();                   cyc(0, 1, 0, 8'h00); endtask
  task automatic by(input logic [7:0] d); cyc(0, 0, 1, d);     endtask

  task automatic do_reset();
    reset = 1; start_i = 0; stop_i = 0; data_valid_i = 0; data_i = 8'h00;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  always @(posedge clk) rst_q <= reset;

  // Monitor: pops expected strobes and checks the active bank never moves otherwise.
  initial begin
    mon_regs = '0;
    forever begin
      @(negedge clk);
      if (wr_pulse_o) begin
        if (wr_q.size() == 0) chk("wr_pulse_unexpected", 64'(1), 64'(0));
        else chk("wr_ptr", 64'(ptr_o), 64'(wr_q.pop_front()));
      end
      if (commit_o) begin
        if (commit_q.size() == 0) chk("commit_unexpected", 64'(1), 64'(0));
        else mon_regs = commit_q.pop_front();
      end else if (rst_q) begin
        mon_regs = '0;
      end
      chk("regs_o", 64'(regs_o), 64'(mon_regs));
    end
  end

  initial begin
    start_i = 0; stop_i = 0; data_valid_i = 0; data_i = 8'h00; reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1; reset = 0;
    check_state("reset");
    chk("reset.wr",     64'(wr_pulse_o), 64'(0));
    chk("reset.commit", 64'(commit_o),   64'(0));
    chk("reset.regs",   64'(regs_o),     64'(0));

    // Basic write, then wrap at the top register
    st(); by(8'h02); by(8'hA5); by(8'h3C);
    chk("pre_commit_regs", 64'(regs_o), 64'(0));
    sp(); cyc(0, 0, 0, 8'h00);
    chk("t1.regs", 64'(regs_o), 64'h0000_0000_3CA5_0000);
    st(); by(8'h07); by(8'h11); by(8'h22); sp(); cyc(0, 0, 0, 8'h00);
    chk("t2.regs", 64'(regs_o), 64'h1100_0000_3CA5_0022);

    // Out-of-range pointer: error, writes dropped, next START clears
    st(); by(8'h09);
    chk("t3.err", 64'(err_o), 64'(1));
    by(8'h77); sp(); cyc(0, 0, 0, 8'h00);
    chk("t3.regs", 64'(regs_o), 64'h1100_0000_3CA5_0022);
    st(); chk("t3.err_clr", 64'(err_o), 64'(0)); sp();

    // Repeated START continues one atomic transaction
    st(); by(8'h01); by(8'h55); st(); by(8'h05); by(8'h66); sp(); cyc(0, 0, 0, 8'h00);
    chk("t4.regs", 64'(regs_o), 64'h1100_6600_3CA5_5522);

    // Pointer-only read setup, START+byte collision, stray IDLE byte
    st(); by(8'h04); sp();
    chk("t5.rd", 64'(rd_data_o), 64'h00);
    by(8'h12);
    st(); cyc(1, 0, 1, 8'h03); by(8'h06); by(8'hEE); cyc(0, 1, 1, 8'hDD);
    cyc(0, 0, 0, 8'h00);
    chk("t5.regs", 64'(regs_o), 64'hDDEE_6600_3CA5_5522);
    cyc(1, 1, 0, 8'h00); sp();

    // Reset mid-transaction, then a lone STOP
    st(); by(8'h03); by(8'h99);
    do_reset();
    check_state("t6");
    chk("t6.regs", 64'(regs_o), 64'(0));
    sp(); cyc(0, 0, 0, 8'h00);
    chk("t6.regs2", 64'(regs_o), 64'(0));

    // Random event streams, including simultaneous events and rare resets
    for (int i = 0; i < 2000; i++) begin
      bit s, p, v;
      logic [7:0] d;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        check_state("rnd_reset");
      end else begin
        s = ($urandom_range(0, 9) == 0);
        p = ($urandom_range(0, 9) == 0);
        v = ($urandom_range(0, 9) < 6);
        d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
        cyc(s, p, v, d);
      end
    end
    sp(); cyc(0, 0, 0, 8'h00); cyc(0, 0, 0, 8'h00);
    chk("end.regs_model", 64'(regs_o), 64'(pack_act()));
    chk("end.wr_q_empty",     64'(wr_q.size()),     64'(0));
    chk("end.commit_q_empty", 64'(commit_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_reg_ctrl.md
# i2c_reg_ctrl

Register-bank controller behind the `i2c` slave. It turns the slave's per-byte event stream (`start`, `stop`, `data`, `data_valid_o`) into pointer-addressed, auto-incrementing writes to a small configuration register bank. Writes land in a shadow bank and are committed atomically to the active bank on STOP. The active bank drives the rest of the design, and the pointer plus read data feed the slave's transmit path.

## Interface
- `NUM_REGS`, default 8: number of 8-bit registers; 2..2^`PTR_W`.
- `PTR_W`, default 3: pointer width.
- `RESET_VALUE`, default 8'h00: reset value of every active and shadow register.

- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  reset; synchronous, active-high.
- `data_i`  in  8  received byte from the slave's `data`.
- `data_valid_i`  in  1  one-`clk` pulse per received data byte after an own-address match. Address bytes are never presented.
- `start_i`  in  1  one-`clk` pulse on START or repeated START.
- `stop_i`  in  1  one-`clk` pulse on STOP.
- `regs_o`  out  NUM_REGS*8  active bank, flattened; register k at [8k+7:8k].
- `rd_data_o`  out  8  active register at `ptr_o` (combinational mux of registered state).
- `ptr_o`  out  PTR_W  current register pointer.
- `wr_pulse_o`  out  1  one-cycle strobe per shadow write.
- `commit_o`  out  1  one-cycle strobe when shadow is copied to active.
- `err_o`  out  1  sticky error; cleared by next `start_i` or reset.
- `busy_o`  out  1  high whenever state is not IDLE.

## Operation
- States:
  - IDLE: waiting for `start_i`.
  - PTR: next byte is the pointer.
  - DATA: bytes are register data.
  - IGNORE: discard bytes until STOP/START.
- Any state, `start_i`: go to PTR; clear `err_o`.
  - `dirty` and shadow are kept, so a repeated START continues the same atomic transaction.
- PTR, `data_valid_i`:
  - If `data_i` < NUM_REGS: `ptr` <= `data_i[PTR_W-1:0]`; go to DATA.
  - Else: set `err_o`; go to IGNORE; `ptr` unchanged.
- DATA, `data_valid_i`:
  - shadow[ptr] <= `data_i`; `wr_pulse_o` = 1; `dirty` <= 1.
  - `ptr` <= ptr+1, wrapping NUM_REGS-1 -> 0.
- IGNORE, `data_valid_i`: byte dropped; no write.
- Any state, `stop_i`:
  - If `dirty` and not `err_o`: active <= shadow; `commit_o` = 1.
  - If `err_o`: shadow <= active (discard staged writes).
  - Clear `dirty`; go to IDLE. `ptr` is retained for subsequent reads.
- IDLE, `data_valid_i`: ignored. This is a protocol violation and does not set `err_o`.
- A pointer-only transaction (START, ptr, STOP) moves `ptr_o` with no commit. This is the read-setup path.

## Timing
- Reset values:
  - Active and shadow registers = RESET_VALUE.
  - `ptr_o` = 0; `wr_pulse_o`, `commit_o`, `err_o`, `busy_o` = 0; `dirty` = 0; state IDLE.
- Event inputs sampled at `clk` edge n take effect at n+1:
  - `data_valid_i` at n -> shadow, `ptr_o`, `wr_pulse_o` updated/high in cycle n+1.
  - `stop_i` at n -> `regs_o` updated and `commit_o` high in cycle n+1.
  - `rd_data_o` follows `ptr_o` and `regs_o` in the same cycle.
- Simultaneous events in one cycle:
  - `start_i` + `data_valid_i`: start wins; byte discarded.
  - `stop_i` + `data_valid_i`: byte processed first, then the STOP/commit rule uses the updated shadow and `dirty`.
  - `start_i` + `stop_i`: STOP handling first (commit/discard), then go to PTR.
- Reset mid-transaction: everything returns to reset values at the next edge; no commit and no strobe.
- Throughput: one byte per cycle sustained. No backpressure is required.

## Test plan
- START, 0x02, 0xA5, 0x3C, STOP -> two `wr_pulse_o`; exactly one `commit_o` the cycle after STOP; reg2=A5, reg3=3C; `ptr_o`=4; others 00; `regs_o` unchanged before commit.
- START, 0x07, 0x11, 0x22, STOP -> reg7=11, reg0=22 (wrap); `ptr_o`=1.
- START, 0x09, 0x77, STOP -> `err_o`=1 from the cycle after 0x09; no `wr_pulse_o`; no `commit_o`; bank unchanged. The next START clears `err_o`.
- START, 0x01, 0x55, START, 0x05, 0x66, STOP -> no commit at the repeated START; single `commit_o` updates reg1=55 and reg5=66 together.
- START, 0x04, STOP -> no commit; `ptr_o`=4; `rd_data_o`=reg4. Separately, `start_i`+`data_valid_i` in the same cycle -> byte dropped, state PTR.
- START, 0x03, 0x99, `reset` before STOP -> all registers 00, `ptr_o`=0, no `commit_o`. A following STOP alone -> no commit.
